// File: rtl/mac_tx_arb.sv
// mac_tx_arb: frame-level round-robin arbiter sharing one MAC TX byte stream
// between two packet sources. A granted source sends one whole frame
// (sof..eof) and is followed by a forced inter-frame gap.
// Optional feature macro: MAC_TX_ARB_WDT_EN adds a per-frame beat watchdog
// (MAX_FRAME parameter, wdt_trip output) that force-terminates runaway frames.
module mac_tx_arb #(
  parameter int TEST_DATA_WIDTH = 8,
  parameter int IFG_CYCLES      = 12,
  parameter int GNT_TIMEOUT     = 16
`ifdef MAC_TX_ARB_WDT_EN
  , parameter int MAX_FRAME     = 2048
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       src0_req,
  output logic                       src0_gnt,
  input  logic [TEST_DATA_WIDTH-1:0] src0_data,
  input  logic                       src0_valid,
  input  logic                       src0_sof,
  input  logic                       src0_eof,
  input  logic                       src1_req,
  output logic                       src1_gnt,
  input  logic [TEST_DATA_WIDTH-1:0] src1_data,
  input  logic                       src1_valid,
  input  logic                       src1_sof,
  input  logic                       src1_eof,
  output logic [TEST_DATA_WIDTH-1:0] mac_tx_data,
  output logic                       mac_tx_valid,
  output logic                       mac_tx_sof,
  output logic                       mac_tx_eof,
  output logic [1:0]                 src_drop,
  output logic [15:0]                frm_cnt0,
  output logic [15:0]                frm_cnt1
`ifdef MAC_TX_ARB_WDT_EN
  , output logic                     wdt_trip
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, XFER = 2'd2, GAP = 2'd3} state_t;

  localparam logic [7:0] TMO_LAST = 8'(GNT_TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST = 8'(IFG_CYCLES - 1);
`ifdef MAC_TX_ARB_WDT_EN
  localparam int BEAT_W = $clog2(MAX_FRAME + 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_FRAME);
`endif

  state_t                     state_q, state_d;
  logic                       sel_q, sel_d;
  logic                       last_q, last_d;
  logic [7:0]                 tmo_q, tmo_d;
  logic [7:0]                 gap_q, gap_d;
  logic [15:0]                frm_cnt0_q, frm_cnt0_d;
  logic [15:0]                frm_cnt1_q, frm_cnt1_d;
  logic [TEST_DATA_WIDTH-1:0] mac_data_q, mac_data_d;
  logic                       mac_valid_q, mac_valid_d;
  logic                       mac_sof_q, mac_sof_d;
  logic                       mac_eof_q, mac_eof_d;
  logic [1:0]                 drop_q, drop_d;
  logic                       gnt0_q, gnt0_d;
  logic                       gnt1_q, gnt1_d;
`ifdef MAC_TX_ARB_WDT_EN
  logic [BEAT_W-1:0]          beat_q, beat_d;
  logic                       wdt_q, wdt_d;
`endif

  logic [TEST_DATA_WIDTH-1:0] sel_data;
  logic                       sel_valid, sel_sof, sel_eof, sel_req;
  logic                       fwd, fin, rel;

  // Route the currently selected source's beat and request to the control logic
  always_comb begin
    sel_data  = sel_q ? src1_data  : src0_data;
    sel_valid = sel_q ? src1_valid : src0_valid;
    sel_sof   = sel_q ? src1_sof   : src0_sof;
    sel_eof   = sel_q ? src1_eof   : src0_eof;
    sel_req   = sel_q ? src1_req   : src0_req;
  end

  // Arbitration FSM: pick a source, wait for its sof, carry the frame, then hold the gap
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    fwd     = 1'b0;
    fin     = 1'b0;
    rel     = 1'b0;
`ifdef MAC_TX_ARB_WDT_EN
    beat_d  = beat_q;
    wdt_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (src0_req && src1_req) begin
          sel_d   = ~last_q;
          state_d = GRANT;
          tmo_d   = '0;
        end else if (src0_req) begin
          sel_d   = 1'b0;
          state_d = GRANT;
          tmo_d   = '0;
        end else if (src1_req) begin
          sel_d   = 1'b1;
          state_d = GRANT;
          tmo_d   = '0;
        end
      end
      GRANT: begin
        if (sel_valid && sel_sof) begin
          fwd = 1'b1;
          if (sel_eof) fin = 1'b1;
          else         state_d = XFER;
`ifdef MAC_TX_ARB_WDT_EN
          beat_d = BEAT_W'(1);
`endif
        end else if (!sel_req || (tmo_q == TMO_LAST)) begin
          rel = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      XFER: begin
`ifdef MAC_TX_ARB_WDT_EN
        // Runaway frame: terminate it ourselves without crediting the source
        if (beat_q == BEAT_MAX) begin
          wdt_d   = 1'b1;
          state_d = GAP;
          gap_d   = '0;
          last_d  = sel_q;
        end else if (sel_valid) begin
          fwd    = 1'b1;
          fin    = sel_eof;
          beat_d = beat_q + 1'b1;
        end
`else
        if (sel_valid) begin
          fwd = 1'b1;
          fin = sel_eof;
        end
`endif
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
    if (rel) begin
      state_d = IDLE;
      last_d  = sel_q;
    end
    if (fin) begin
      state_d = GAP;
      gap_d   = '0;
      last_d  = sel_q;
    end
  end

  // Next MAC beat, drop pulses, grants and completed-frame counters
  always_comb begin
    mac_data_d  = mac_data_q;
    mac_valid_d = 1'b0;
    mac_sof_d   = 1'b0;
    mac_eof_d   = 1'b0;
    if (fwd) begin
      mac_data_d  = sel_data;
      mac_valid_d = 1'b1;
      mac_sof_d   = sel_sof;
      mac_eof_d   = sel_eof;
    end
`ifdef MAC_TX_ARB_WDT_EN
    if (wdt_d) begin
      mac_data_d  = '0;
      mac_valid_d = 1'b1;
      mac_eof_d   = 1'b1;
    end
`endif
    drop_d[0]  = src0_valid && !(fwd && !sel_q);
    drop_d[1]  = src1_valid && !(fwd && sel_q);
    gnt0_d     = ((state_d == GRANT) || (state_d == XFER)) && !sel_d;
    gnt1_d     = ((state_d == GRANT) || (state_d == XFER)) && sel_d;
    frm_cnt0_d = frm_cnt0_q + {15'd0, fin && !sel_q};
    frm_cnt1_d = frm_cnt1_q + {15'd0, fin && sel_q};
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      tmo_q       <= '0;
      gap_q       <= '0;
      frm_cnt0_q  <= '0;
      frm_cnt1_q  <= '0;
      mac_data_q  <= '0;
      mac_valid_q <= 1'b0;
      mac_sof_q   <= 1'b0;
      mac_eof_q   <= 1'b0;
      drop_q      <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
`ifdef MAC_TX_ARB_WDT_EN
      beat_q      <= '0;
      wdt_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      tmo_q       <= tmo_d;
      gap_q       <= gap_d;
      frm_cnt0_q  <= frm_cnt0_d;
      frm_cnt1_q  <= frm_cnt1_d;
      mac_data_q  <= mac_data_d;
      mac_valid_q <= mac_valid_d;
      mac_sof_q   <= mac_sof_d;
      mac_eof_q   <= mac_eof_d;
      drop_q      <= drop_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
`ifdef MAC_TX_ARB_WDT_EN
      beat_q      <= beat_d;
      wdt_q       <= wdt_d;
`endif
    end
  end

  assign src0_gnt     = gnt0_q;
  assign src1_gnt     = gnt1_q;
  assign mac_tx_data  = mac_data_q;
  assign mac_tx_valid = mac_valid_q;
  assign mac_tx_sof   = mac_sof_q;
  assign mac_tx_eof   = mac_eof_q;
  assign src_drop     = drop_q;
  assign frm_cnt0     = frm_cnt0_q;
  assign frm_cnt1     = frm_cnt1_q;
`ifdef MAC_TX_ARB_WDT_EN
  assign wdt_trip     = wdt_q;
`endif

endmodule

// File: tb/tb_mac_tx_arb.sv
// Testbench for mac_tx_arb: randomized frames from two sources, a scoreboard of
// expected MAC beats, and end-of-test checks of drops and frame counters.
// Define MAC_TX_ARB_WDT_EN to also exercise the frame watchdog.
`timescale 1ns/1ps
module tb_mac_tx_arb;
  localparam int DW  = 8;
  localparam int IFG = 12;
  localparam int TMO = 16;
`ifdef MAC_TX_ARB_WDT_EN
  localparam int MAXF   = 32;
  localparam int T1_LEN = 32;
`else
  localparam int T1_LEN = 64;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rst_s = 1'b0;
  logic          src0_req = 0, src0_valid = 0, src0_sof = 0, src0_eof = 0;
  logic          src1_req = 0, src1_valid = 0, src1_sof = 0, src1_eof = 0;
  logic [DW-1:0] src0_data = '0, src1_data = '0;
  logic          src0_gnt, src1_gnt;
  logic [DW-1:0] mac_tx_data;
  logic          mac_tx_valid, mac_tx_sof, mac_tx_eof;
  logic [1:0]    src_drop;
  logic [15:0]   frm_cnt0, frm_cnt1;
`ifdef MAC_TX_ARB_WDT_EN
  logic          wdt_trip;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sof;
    logic          eof;
  } beat_t;

  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    drop_seen[2] = '{0, 0};
  int    drop_exp[2]  = '{0, 0};
  int    cnt_model[2] = '{0, 0};
  int    last_model = 1;
  int    wdt_seen = 0;
  int    cyc = 0;
  int    eof_cyc = 0;
  bit    have_eof = 0;

  mac_tx_arb #(
    .TEST_DATA_WIDTH(DW),
    .IFG_CYCLES(IFG),
    .GNT_TIMEOUT(TMO)
`ifdef MAC_TX_ARB_WDT_EN
    , .MAX_FRAME(MAXF)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .src0_req(src0_req), .src0_gnt(src0_gnt), .src0_data(src0_data),
    .src0_valid(src0_valid), .src0_sof(src0_sof), .src0_eof(src0_eof),
    .src1_req(src1_req), .src1_gnt(src1_gnt), .src1_data(src1_data),
    .src1_valid(src1_valid), .src1_sof(src1_sof), .src1_eof(src1_eof),
    .mac_tx_data(mac_tx_data), .mac_tx_valid(mac_tx_valid),
    .mac_tx_sof(mac_tx_sof), .mac_tx_eof(mac_tx_eof),
    .src_drop(src_drop), .frm_cnt0(frm_cnt0), .frm_cnt1(frm_cnt1)
`ifdef MAC_TX_ARB_WDT_EN
    , .wdt_trip(wdt_trip)
`endif
  );

  initial forever #5 clk = ~clk;

  // Remember whether the edge that produced the current outputs was a reset edge
  always @(posedge clk) rst_s <= rst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the MAC side presents a beat
  initial begin
    beat_t e;
    int    idle;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_s) begin
        have_eof = 0;
      end else begin
        if (src_drop[0]) drop_seen[0]++;
        if (src_drop[1]) drop_seen[1]++;
`ifdef MAC_TX_ARB_WDT_EN
        if (wdt_trip) begin
          wdt_seen++;
          check("wdt_forced_beat", {21'd0, mac_tx_valid, mac_tx_eof, mac_tx_data},
                {21'd0, 1'b1, 1'b1, 8'h00});
        end
`endif
        if (mac_tx_valid) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL mac_unexpected_beat: got data 0x%0h sof %0b eof %0b, expected no beat",
                     mac_tx_data, mac_tx_sof, mac_tx_eof);
          end else begin
            e = exp_q.pop_front();
            check("mac_beat", {22'd0, mac_tx_data, mac_tx_sof, mac_tx_eof},
                  {22'd0, e.data, e.sof, e.eof});
          end
          if (have_eof) begin
            idle = cyc - eof_cyc - 1;
            check("ifg_idle_ge_ifg", 32'(idle >= IFG), 32'd1);
            have_eof = 0;
          end
          if (mac_tx_eof) begin
            have_eof = 1;
            eof_cyc  = cyc;
          end
        end
      end
    end
  end

  task automatic drive(input int s, input logic [DW-1:0] d, input bit v, input bit sf, input bit ef);
    if (s == 0) begin
      src0_data = d; src0_valid = v; src0_sof = sf; src0_eof = ef;
    end else begin
      src1_data = d; src1_valid = v; src1_sof = sf; src1_eof = ef;
    end
  endtask

  task automatic idle_all();
    drive(0, '0, 0, 0, 0);
    drive(1, '0, 0, 0, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_mac_gnt_drop"},
          {17'd0, mac_tx_valid, mac_tx_sof, mac_tx_eof, mac_tx_data, src0_gnt, src1_gnt, src_drop},
          32'd0);
    check({tag, "_frm_cnt0"}, {16'd0, frm_cnt0}, 32'd0);
    check({tag, "_frm_cnt1"}, {16'd0, frm_cnt1}, 32'd0);
`ifdef MAC_TX_ARB_WDT_EN
    check({tag, "_wdt_trip"}, {31'd0, wdt_trip}, 32'd0);
`endif
  endtask

  task automatic model_reset();
    cnt_model[0] = 0;
    cnt_model[1] = 0;
    last_model   = 1;
  endtask

  task automatic do_reset();
    rst = 0;
    src0_req = 0;
    src1_req = 0;
    idle_all();
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    check("reset_queue_drained", 32'(exp_q.size()), 32'd0);
    model_reset();
    rst = 1;
  endtask

  task automatic wait_gnt(input int s, input int limit, output int waited);
    waited = 0;
    while (!(s == 0 ? src0_gnt : src1_gnt) && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= limit) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_gnt%0d: got no grant in %0d cycles, expected a grant", s, limit);
    end
  endtask

  // Drive one frame from source s; the model decides which beats reach the MAC
  task automatic send_frame(input int s, input int len, input logic [DW-1:0] base,
                            input bit gaps, input bit noise, input bit with_eof);
    int    i = 0;
    int    nacc = 0;
    bit    forced = 0;
    bit    gap;
    int    o = 1 - s;
    beat_t b;
    while (i < len) begin
      gap = gaps && (i > 0) && ($urandom_range(0, 3) == 0);
      if (gap) drive(s, '0, 0, 0, 0);
      else     drive(s, base + DW'(i), 1, i == 0, with_eof && (i == len - 1));
      if (noise && ($urandom_range(0, 1) == 1)) begin
        drive(o, DW'($urandom), 1, 1'($urandom), 1'($urandom));
        drop_exp[o]++;
      end else begin
        drive(o, '0, 0, 0, 0);
      end
      if (forced) begin
        if (!gap) drop_exp[s]++;
`ifdef MAC_TX_ARB_WDT_EN
      end else if (nacc == MAXF) begin
        b = '{data: '0, sof: 1'b0, eof: 1'b1};
        exp_q.push_back(b);
        forced = 1;
        if (!gap) drop_exp[s]++;
`endif
      end else if (!gap) begin
        b = '{data: base + DW'(i), sof: i == 0, eof: with_eof && (i == len - 1)};
        exp_q.push_back(b);
        nacc++;
      end
      if (!gap) i++;
      @(negedge clk);
    end
    idle_all();
    if (!forced && with_eof) cnt_model[s]++;
    last_model = s;
  endtask

  task automatic finish_test();
    repeat (IFG + 4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("drop0_count", 32'(drop_seen[0]), 32'(drop_exp[0]));
    check("drop1_count", 32'(drop_seen[1]), 32'(drop_exp[1]));
    check("frm_cnt0", {16'd0, frm_cnt0}, 32'(cnt_model[0]));
    check("frm_cnt1", {16'd0, frm_cnt1}, 32'(cnt_model[1]));
  endtask

  initial begin
    int w;
    int n;
    int got;
    idle_all();
    do_reset();

    // Single long frame from source 0
    src0_req = 1;
    wait_gnt(0, 50, w);
    src0_req = 0;
    send_frame(0, T1_LEN, 8'h00, 0, 0, 1);
    finish_test();

    // Both sources requesting: grants must alternate
    do_reset();
    src0_req = 1;
    src1_req = 1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(src0_gnt || src1_gnt) && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("rr_grant_seen", 32'(n < 200), 32'd1);
      check("rr_gnt_exclusive", {31'd0, src0_gnt & src1_gnt}, 32'd0);
      got = src1_gnt ? 1 : 0;
      check("rr_order", 32'(got), 32'(last_model == 0 ? 1 : 0));
      send_frame(got, 16, DW'(8'h40 + 16 * k), 1, 0, 1);
    end
    src0_req = 0;
    src1_req = 0;
    finish_test();

    // Source 1 granted but silent: grant withdrawn after the timeout
    src1_req = 1;
    wait_gnt(1, 50, w);
    src0_req = 1;
    n = 0;
    while (src1_gnt && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("gnt_timeout_len", 32'(n), 32'(TMO));
    src1_req = 0;
    last_model = 1;
    wait_gnt(0, 50, w);
    check("post_timeout_src0_soon", 32'(w <= 2), 32'd1);
    check("post_timeout_gnt1_low", {31'd0, src1_gnt}, 32'd0);
    src0_req = 0;
    send_frame(0, 8, 8'hC0, 1, 0, 1);
    finish_test();

    // Source 1 chatters while source 0 owns the MAC
    src0_req = 1;
    wait_gnt(0, 50, w);
    src0_req = 0;
    send_frame(0, 24, 8'hA0, 1, 1, 1);
    finish_test();

    // Reset in the middle of a frame (asserted on the 10th beat)
    src0_req = 1;
    wait_gnt(0, 50, w);
    src0_req = 0;
    for (int i = 0; i < 9; i++) begin
      beat_t b;
      drive(0, 8'h10 + DW'(i), 1, i == 0, 0);
      b = '{data: 8'h10 + DW'(i), sof: i == 0, eof: 1'b0};
      exp_q.push_back(b);
      @(negedge clk);
    end
    drive(0, 8'h19, 1, 0, 0);
    rst = 0;
    @(negedge clk);
    idle_all();
    check_zero_outputs("midframe_reset");
    @(negedge clk);
    check("midframe_queue_drained", 32'(exp_q.size()), 32'd0);
    model_reset();
    rst = 1;
    finish_test();

`ifdef MAC_TX_ARB_WDT_EN
    // Runaway frame with no eof: watchdog terminates it
    src0_req = 1;
    wait_gnt(0, 50, w);
    src0_req = 0;
    send_frame(0, 40, 8'h80, 0, 0, 0);
    finish_test();
    check("wdt_trip_pulses", 32'(wdt_seen), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench still running at %0t, expected completion", $time);
    $fatal(1, "global timeout");
  end

endmodule
